// File: rtl/sub_bytes_seq.sv
// -----------------------------------------------------------------------------
// sub_bytes_seq -- AES SubBytes stage, one column (4 S-boxes) per cycle.
//
// A 128-bit AES state is captured on an IN_VALID/IN_READY handshake. It is
// substituted column by column (column 0 first) over four cycles. The result
// is then held on OUT_DATA with OUT_VALID until the consumer asserts OUT_READY.
//
// Ports
//   clk        in   1    rising-edge clock
//   rst        in   1    asynchronous, active-high reset
//   IN_VALID   in   1    upstream offers IN_DATA
//   IN_READY   out  1    block is idle and can take a state
//   IN_DATA    in   128  AES state, column-major, byte 0 = [127:120]
//   OUT_VALID  out  1    OUT_DATA holds a finished SubBytes result
//   OUT_READY  in   1    downstream takes OUT_DATA
//   OUT_DATA   out  128  substituted state, same byte layout as IN_DATA
//   BUSY       out  1    block is not idle
// -----------------------------------------------------------------------------

// Forward AES S-box for one byte. The byte is computed rather than looked up:
// it is the multiplicative inverse in GF(2^8) followed by the affine transform.
module sub_bytes_sbox (
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  // Multiplication modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^-1 = x^254 = x^(2+4+...+128). This maps 0 to 0, which is what the S-box
  // needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = x;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  logic [7:0] inv;

  always_comb begin
    inv    = gf_inv(byte_i);
    byte_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
           ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

module sub_bytes_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [127:0] IN_DATA,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [127:0] OUT_DATA,
  output logic         BUSY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q;
  logic [1:0]   cnt_q;
  logic [127:0] work_q;
  logic [127:0] work_d;
  logic [31:0]  col_in;
  logic [31:0]  col_out;

  // Select the column that is currently being substituted.
  always_comb begin
    col_in = work_q[127:96];
    case (cnt_q)
      2'd0:    col_in = work_q[127:96];
      2'd1:    col_in = work_q[95:64];
      2'd2:    col_in = work_q[63:32];
      default: col_in = work_q[31:0];
    endcase
  end

  // The four shared S-boxes, one per byte of the selected column.
  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    sub_bytes_sbox u_sbox (
      .byte_i(col_in[31-8*gi -: 8]),
      .byte_o(col_out[31-8*gi -: 8])
    );
  end

  // Write the substituted column back in place. Every other column keeps
  // its value, so unprocessed columns still hold the captured input.
  for (genvar gi = 0; gi < 4; gi++) begin : g_work
    assign work_d[127-32*gi -: 32] = (cnt_q == 2'(gi)) ? col_out
                                                       : work_q[127-32*gi -: 32];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      work_q  <= 128'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (IN_VALID) begin
            work_q  <= IN_DATA;
            cnt_q   <= 2'd0;
            state_q <= SUB;
          end
        end
        SUB: begin
          work_q <= work_d;
          cnt_q  <= cnt_q + 2'd1;       // wraps to 0 after column 3
          if (cnt_q == 2'd3) state_q <= DONE;
        end
        DONE: begin
          // Acceptance happens only from IDLE. Input and output transfers
          // therefore never share an edge.
          if (OUT_READY) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // IN_READY is gated by rst so that it is low while reset is held.
  assign IN_READY  = (state_q == IDLE) && !rst;
  assign OUT_VALID = (state_q == DONE);
  assign BUSY      = (state_q != IDLE);
  assign OUT_DATA  = work_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// -----------------------------------------------------------------------------
// tb_sub_bytes_seq -- self-checking bench for sub_bytes_seq.
// The reference model substitutes whole 128-bit states by table lookup in the
// published AES S-box. A scoreboard pairs every accepted input with its
// output transfer.
// -----------------------------------------------------------------------------
module tb_sub_bytes_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         IN_VALID;
  logic         IN_READY;
  logic [127:0] IN_DATA;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [127:0] OUT_DATA;
  logic         BUSY;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_cnt  = 0;
  int blk_no   = 0;

  logic [127:0] exp_q [$];
  int           acc_cyc [$];
  logic [127:0] sbox_rows [16];

  sub_bytes_seq dut (
    .clk      (clk),
    .rst      (rst),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .IN_DATA  (IN_DATA),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .OUT_DATA (OUT_DATA),
    .BUSY     (BUSY)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sb(input logic [7:0] v);
    logic [127:0] row;
    int           col;
    row = sbox_rows[v[7:4]];
    col = int'(v[3:0]);
    return row[127-8*col -: 8];
  endfunction

  function automatic logic [127:0] ref_sub(input logic [127:0] x);
    logic [127:0] r;
    for (int j = 0; j < 16; j++) r[127-8*j -: 8] = sb(x[127-8*j -: 8]);
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Scoreboard: sample the handshakes at the clock edge (pre-update values).
  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (!rst) begin
      if (IN_VALID && IN_READY) begin
        exp_q.push_back(ref_sub(IN_DATA));
        acc_cyc.push_back(cyc_cnt);
      end
      if (OUT_VALID && OUT_READY) begin
        if (exp_q.size() == 0) chk("spurious_output", {127'b0, OUT_VALID}, 128'h0);
        else                   chk("scoreboard", OUT_DATA, exp_q.pop_front());
      end
    end
  end

  always @(posedge rst) exp_q.delete();

  // One full transaction: offer data, measure latency, hold DONE for 'hold'
  // extra cycles with OUT_READY low, then release.
  task automatic run_block(input logic [127:0] data, input int hold, output logic [127:0] result);
    int lat;
    logic [127:0] expv;
    expv = ref_sub(data);
    for (int i = 0; i < 20 && !IN_READY; i++) @(negedge clk);
    chk("ready_before_accept", IN_READY, 1'b1);
    OUT_READY = (hold == 0);
    IN_VALID  = 1'b1;
    IN_DATA   = data;
    @(negedge clk);
    IN_VALID = 1'b0;
    IN_DATA  = rnd128();
    chk("busy_after_accept", BUSY, 1'b1);
    chk("ready_low_in_sub", IN_READY, 1'b0);
    lat = 1;
    while (!OUT_VALID && lat < 20) begin
      @(negedge clk);
      lat++;
      IN_DATA = rnd128();
    end
    chk("latency", lat, 5);
    chk("out_data", OUT_DATA, expv);
    result = OUT_DATA;
    for (int i = 0; i < hold; i++) begin
      IN_VALID = 1'b1;                 // offering in DONE must be ignored
      IN_DATA  = rnd128();
      @(negedge clk);
      chk("hold_valid", OUT_VALID, 1'b1);
      chk("hold_data", OUT_DATA, expv);
      chk("hold_ready_low", IN_READY, 1'b0);
    end
    OUT_READY = 1'b1;
    IN_VALID  = 1'b1;                  // no accept in the DONE cycle
    @(negedge clk);
    IN_VALID = 1'b0;
    chk("idle_after_out", BUSY, 1'b0);
    chk("ready_after_out", IN_READY, 1'b1);
    chk("valid_after_out", OUT_VALID, 1'b0);
    $display("block %0d in=%h out=%h latency=%0d hold=%0d", blk_no, data, result, lat, hold);
    blk_no++;
  endtask

  initial begin
    logic [127:0] res;
    logic [127:0] a, b, blk;
    int n0;

    sbox_rows[0]  = 128'h637c777bf26b6fc53001672bfed7ab76;
    sbox_rows[1]  = 128'hca82c97dfa5947f0add4a2af9ca472c0;
    sbox_rows[2]  = 128'hb7fd9326363ff7cc34a5e5f171d83115;
    sbox_rows[3]  = 128'h04c723c31896059a071280e2eb27b275;
    sbox_rows[4]  = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
    sbox_rows[5]  = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
    sbox_rows[6]  = 128'hd0efaafb434d338545f9027f503c9fa8;
    sbox_rows[7]  = 128'h51a3408f929d38f5bcb6da2110fff3d2;
    sbox_rows[8]  = 128'hcd0c13ec5f974417c4a77e3d645d1973;
    sbox_rows[9]  = 128'h60814fdc222a908846eeb814de5e0bdb;
    sbox_rows[10] = 128'he0323a0a4906245cc2d3ac629195e479;
    sbox_rows[11] = 128'he7c8376d8dd54ea96c56f4ea657aae08;
    sbox_rows[12] = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
    sbox_rows[13] = 128'h703eb5664803f60e613557b986c11d9e;
    sbox_rows[14] = 128'he1f8981169d98e949b1e87e9ce5528df;
    sbox_rows[15] = 128'h8ca1890dbfe6426841992d0fb054bb16;

    // Reset state
    rst = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0; IN_DATA = 128'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", IN_READY, 1'b0);
    chk("rst_out_valid", OUT_VALID, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_out_data", OUT_DATA, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", IN_READY, 1'b1);

    // OUT_READY while idle must do nothing
    OUT_READY = 1'b1;
    @(negedge clk);
    chk("idle_out_ready_valid", OUT_VALID, 1'b0);
    chk("idle_out_ready_busy", BUSY, 1'b0);

    // All-zero state
    run_block(128'h0, 0, res);
    chk("zero_vector", res, 128'h63636363636363636363636363636363);

    // Known-answer vector (AES round 1 SubBytes)
    run_block(128'h193de3bea0f4e22b9ac68d2ae9f84808, 0, res);
    chk("kat_vector", res, 128'hd42711aee0bf98f1b8b45de51e415230);

    // Back-pressure: OUT_READY low for 10 cycles
    run_block(rnd128(), 10, res);

    // IN_VALID held high across two states; junk during SUB is ignored
    a = rnd128();
    b = rnd128();
    OUT_READY = 1'b1;
    for (int i = 0; i < 20 && !IN_READY; i++) @(negedge clk);
    n0 = acc_cyc.size();
    IN_VALID = 1'b1;
    IN_DATA  = a;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) IN_DATA = rnd128();
      if (c == 3) IN_DATA = b;
      if (c == 7) IN_VALID = 1'b0;
    end
    chk("b2b_accept_count", acc_cyc.size() - n0, 2);
    if (acc_cyc.size() >= n0 + 2)
      chk("b2b_spacing", acc_cyc[n0+1] - acc_cyc[n0], 6);
    chk("b2b_idle", BUSY, 1'b0);
    $display("block pair a=%h b=%h back-to-back", a, b);

    // Every byte value 0x00..0xFF, spread across all byte positions
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 16; j++) blk[127-8*j -: 8] = 8'(16*k + ((j + k) % 16));
      run_block(blk, 0, res);
    end

    // Random states with random back-pressure
    for (int k = 0; k < 6; k++) run_block(rnd128(), int'($urandom_range(0, 3)), res);

    // Asynchronous reset at CNT == 2 aborts the block
    OUT_READY = 1'b1;
    for (int i = 0; i < 20 && !IN_READY; i++) @(negedge clk);
    IN_VALID = 1'b1;
    IN_DATA  = rnd128();
    @(negedge clk);
    IN_VALID = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_busy_before", BUSY, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("abort_out_valid", OUT_VALID, 1'b0);
    chk("abort_busy", BUSY, 1'b0);
    chk("abort_out_data", OUT_DATA, 128'h0);
    chk("abort_in_ready", IN_READY, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_ready_after", IN_READY, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_output", OUT_VALID, 1'b0);
    end
    $display("block aborted by reset");
    run_block(rnd128(), 1, res);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
